// File: rtl/ima_adpcm_blk_ctrl.sv
// IMA ADPCM block controller.
// Sequences one IMA ADPCM encoder to build WAV-style blocks: a two-word header
// (predictor sample, step index) followed by 4-bit codes packed into 16-bit words.
// Optional feature macro: ADPCM_BLK_FLUSH_EN adds a 'flush' input that ends the
// current block early, padding the open word with zero nibbles.
module ima_adpcm_blk_ctrl #(
   parameter int SPB = 8,
   parameter int CW  = 12
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic [15:0]   srcSamp,
   input  logic          srcValid,
   output logic          srcReady,
   output logic [15:0]   encSamp,
   output logic          encValid,
   input  logic          encReady,
   input  logic [3:0]    encPCM,
   input  logic          encPcmValid,
   input  logic [15:0]   encPredSamp,
   input  logic [6:0]    encStepIndex,
`ifdef ADPCM_BLK_FLUSH_EN
   input  logic          flush,
`endif
   output logic [15:0]   outWord,
   output logic          outValid,
   input  logic          outReady,
   output logic          outSof,
   output logic          outEof,
   output logic [CW-1:0] blkCount
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StHdr0 = 2'd1;
   localparam logic [1:0] StHdr1 = 2'd2;
   localparam logic [1:0] StData = 2'd3;

   // The sample counters carry one extra bit so they can reach SPB itself.
   localparam logic [CW:0] SpbC = (CW+1)'(SPB);

   logic [1:0]    state_q, state_d;
   logic [15:0]   predCap_q, predCap_d;
   logic [6:0]    idxCap_q, idxCap_d;
   logic [CW:0]   issued_q, issued_d;
   logic [CW:0]   packed_q, packed_d;
   logic [1:0]    pack_q, pack_d;
   logic [11:0]   packWord_q, packWord_d;
   logic          busy_q, busy_d;
   logic          flushing_q, flushing_d;
   logic [15:0]   encSamp_q, encSamp_d;
   logic          encValid_q, encValid_d;
   logic [15:0]   outWord_q, outWord_d;
   logic          outValid_q, outValid_d;
   logic          outSof_q, outSof_d;
   logic          outEof_q, outEof_d;
   logic [CW-1:0] blkCount_q, blkCount_d;

   logic          flushReq;
   logic          canLoad;
   logic          wordFull;
   logic          issueOk;
   logic          accept;
   logic          nibValid;
   logic          padValid;
   logic          nibStep;
   logic [3:0]    nibVal;
   logic          lastNib;

`ifdef ADPCM_BLK_FLUSH_EN
   assign flushReq = flush;
`else
   assign flushReq = 1'b0;
`endif

   // Handshake qualifiers: holding register space, the issue rule, and nibble sources.
   // A sample is never issued whose code could complete a word with nowhere to put it.
   always_comb begin
      canLoad  = !outValid_q || outReady;
      wordFull = (pack_q == 2'd3) && outValid_q && !outReady;
      issueOk  = (state_q == StData) && !flushing_q && encReady && !busy_q &&
                 (issued_q < SpbC) && !wordFull;
      accept   = srcValid && issueOk;
      nibValid = encPcmValid && busy_q;
      padValid = (state_q == StData) && flushing_q && !busy_q &&
                 ((pack_q != 2'd3) || canLoad);
      nibStep  = nibValid || padValid;
      nibVal   = nibValid ? encPCM : 4'h0;
      lastNib  = ((packed_q + 1'b1) == SpbC) || flushing_q;
   end

   // Next-state logic: block FSM, sample issue, nibble packing and the output holding register.
   always_comb begin
      state_d    = state_q;
      predCap_d  = predCap_q;
      idxCap_d   = idxCap_q;
      issued_d   = issued_q;
      packed_d   = packed_q;
      pack_d     = pack_q;
      packWord_d = packWord_q;
      busy_d     = busy_q;
      flushing_d = flushing_q;
      encSamp_d  = encSamp_q;
      encValid_d = 1'b0;
      outWord_d  = outWord_q;
      outValid_d = outValid_q;
      outSof_d   = outSof_q;
      outEof_d   = outEof_q;
      blkCount_d = blkCount_q;

      if (outValid_q && outReady) begin
         outValid_d = 1'b0;
         outSof_d   = 1'b0;
         outEof_d   = 1'b0;
      end

      if (accept) begin
         encSamp_d  = srcSamp;
         encValid_d = 1'b1;
         busy_d     = 1'b1;
         issued_d   = issued_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (enable && !busy_q) begin
               predCap_d  = encPredSamp;
               idxCap_d   = encStepIndex;
               issued_d   = '0;
               packed_d   = '0;
               pack_d     = 2'd0;
               packWord_d = 12'h000;
               flushing_d = 1'b0;
               state_d    = StHdr0;
            end
         end
         StHdr0: begin
            if (canLoad) begin
               outWord_d  = predCap_q;
               outValid_d = 1'b1;
               outSof_d   = 1'b1;
               outEof_d   = 1'b0;
               state_d    = StHdr1;
            end
         end
         StHdr1: begin
            if (canLoad) begin
               outWord_d  = {9'b0, idxCap_q};
               outValid_d = 1'b1;
               outSof_d   = 1'b0;
               outEof_d   = 1'b0;
               state_d    = StData;
            end
         end
         default: begin
            if (flushReq) begin
               flushing_d = 1'b1;
            end
            if (nibStep) begin
               if (nibValid) begin
                  busy_d = 1'b0;
               end
               packed_d = packed_q + 1'b1;
               if (pack_q == 2'd3) begin
                  outWord_d  = {nibVal, packWord_q};
                  outValid_d = 1'b1;
                  outSof_d   = 1'b0;
                  outEof_d   = lastNib;
                  pack_d     = 2'd0;
                  packWord_d = 12'h000;
                  if (lastNib) begin
                     blkCount_d = blkCount_q + 1'b1;
                     flushing_d = 1'b0;
                     state_d    = StIdle;
                  end
               end else begin
                  case (pack_q)
                     2'd0:    packWord_d[3:0]  = nibVal;
                     2'd1:    packWord_d[7:4]  = nibVal;
                     default: packWord_d[11:8] = nibVal;
                  endcase
                  pack_d = pack_q + 2'd1;
               end
            end
         end
      endcase
   end

   // State registers; reset discards any partial block and returns to IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         predCap_q  <= '0;
         idxCap_q   <= '0;
         issued_q   <= '0;
         packed_q   <= '0;
         pack_q     <= '0;
         packWord_q <= '0;
         busy_q     <= 1'b0;
         flushing_q <= 1'b0;
         encSamp_q  <= '0;
         encValid_q <= 1'b0;
         outWord_q  <= '0;
         outValid_q <= 1'b0;
         outSof_q   <= 1'b0;
         outEof_q   <= 1'b0;
         blkCount_q <= '0;
      end else begin
         state_q    <= state_d;
         predCap_q  <= predCap_d;
         idxCap_q   <= idxCap_d;
         issued_q   <= issued_d;
         packed_q   <= packed_d;
         pack_q     <= pack_d;
         packWord_q <= packWord_d;
         busy_q     <= busy_d;
         flushing_q <= flushing_d;
         encSamp_q  <= encSamp_d;
         encValid_q <= encValid_d;
         outWord_q  <= outWord_d;
         outValid_q <= outValid_d;
         outSof_q   <= outSof_d;
         outEof_q   <= outEof_d;
         blkCount_q <= blkCount_d;
      end
   end

   assign srcReady = issueOk;
   assign encSamp  = encSamp_q;
   assign encValid = encValid_q;
   assign outWord  = outWord_q;
   assign outValid = outValid_q;
   assign outSof   = outSof_q;
   assign outEof   = outEof_q;
   assign blkCount = blkCount_q;

`ifndef SYNTHESIS
   // A code from the encoder with no sample outstanding is a protocol error.
   noStrayPcm: assert property (@(posedge clock) disable iff (reset) !(encPcmValid && !busy_q));
`endif

endmodule
